// File: rtl/triangle_raster_gen.sv
// Triangle rasteriser: collects three vertices, scans the bounding box row-major,
// and streams every lattice point inside or on the triangle over a valid/ready port.
module triangle_raster_gen #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         vin_valid,
  output logic         vin_ready,
  input  logic [W-1:0] xi,
  input  logic [W-1:0] yi,
  input  logic         edge_only,
  output logic         busy,
  output logic         po,
  input  logic         po_ready,
  output logic [W-1:0] xo,
  output logic [W-1:0] yo,
  output logic         done
);

  localparam int unsigned EW = 2 * W + 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SCAN  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] x0_q, y0_q, x1_q, y1_q, x2_q, y2_q;
  logic [W-1:0] x0_d, y0_d, x1_d, y1_d, x2_d, y2_d;
  logic         eo_q, eo_d;
  logic [W-1:0] xmin_q, xmax_q, ymin_q, ymax_q;
  logic [W-1:0] xmin_d, xmax_d, ymin_d, ymax_d;
  logic [W-1:0] cx_q, cy_q, cx_d, cy_d;
  logic         po_q, po_d;
  logic [W-1:0] xo_q, yo_q, xo_d, yo_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  function automatic logic signed [EW-1:0] sx(input logic [W-1:0] v);
    return $signed({{(EW-W){1'b0}}, v});
  endfunction

  function automatic logic signed [EW-1:0] edge_fn(
    input logic [W-1:0] xa, input logic [W-1:0] ya,
    input logic [W-1:0] xb, input logic [W-1:0] yb,
    input logic [W-1:0] px, input logic [W-1:0] py);
    return (sx(xb) - sx(xa)) * (sx(py) - sx(ya)) - (sx(yb) - sx(ya)) * (sx(px) - sx(xa));
  endfunction

  function automatic logic [W-1:0] min3(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] c);
    logic [W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [W-1:0] max3(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] c);
    logic [W-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  logic                 accept_c, stall_c, last_c, inside_c, on_edge_c, pass_c;
  logic signed [EW-1:0] e01_c, e12_c, e20_c;

  assign vin_ready = (state_q == S_IDLE);
  assign accept_c  = vin_valid && (state_q == S_IDLE);
  assign stall_c   = po_q && !po_ready;
  assign last_c    = (cx_q == xmax_q) && (cy_q == ymax_q);

  // Sign-agnostic inside test so either winding (and collinear input) works.
  assign e01_c     = edge_fn(x0_q, y0_q, x1_q, y1_q, cx_q, cy_q);
  assign e12_c     = edge_fn(x1_q, y1_q, x2_q, y2_q, cx_q, cy_q);
  assign e20_c     = edge_fn(x2_q, y2_q, x0_q, y0_q, cx_q, cy_q);
  assign inside_c  = ((e01_c >= 0) && (e12_c >= 0) && (e20_c >= 0)) ||
                     ((e01_c <= 0) && (e12_c <= 0) && (e20_c <= 0));
  assign on_edge_c = (e01_c == 0) || (e12_c == 0) || (e20_c == 0);
  assign pass_c    = inside_c && (!eo_q || on_edge_c);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_c && (cnt_q == 2'd2)) state_d = S_SETUP;
      S_SETUP: state_d = S_SCAN;
      S_SCAN:  if (!stall_c && last_c) state_d = S_DRAIN;
      S_DRAIN: if (!po_q || po_ready) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    x0_d   = x0_q;   y0_d = y0_q;
    x1_d   = x1_q;   y1_d = y1_q;
    x2_d   = x2_q;   y2_d = y2_q;
    eo_d   = eo_q;
    xmin_d = xmin_q; xmax_d = xmax_q;
    ymin_d = ymin_q; ymax_d = ymax_q;
    cx_d   = cx_q;   cy_d = cy_q;
    po_d   = po_q;
    xo_d   = xo_q;   yo_d = yo_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (cnt_q == 2'd0) begin
            x0_d  = xi; y0_d = yi;
            cnt_d = 2'd1;
          end else if (cnt_q == 2'd1) begin
            x1_d  = xi; y1_d = yi;
            cnt_d = 2'd2;
          end else begin
            x2_d   = xi; y2_d = yi;
            eo_d   = edge_only;
            busy_d = 1'b1;
            cnt_d  = 2'd0;
          end
        end
      end
      S_SETUP: begin
        xmin_d = min3(x0_q, x1_q, x2_q);
        xmax_d = max3(x0_q, x1_q, x2_q);
        ymin_d = min3(y0_q, y1_q, y2_q);
        ymax_d = max3(y0_q, y1_q, y2_q);
        cx_d   = min3(x0_q, x1_q, x2_q);
        cy_d   = min3(y0_q, y1_q, y2_q);
      end
      S_SCAN: begin
        if (!stall_c) begin
          po_d = pass_c;
          if (pass_c) begin
            xo_d = cx_q;
            yo_d = cy_q;
          end
          // Compare before incrementing so a full-range box never wraps.
          if (cx_q != xmax_q) begin
            cx_d = cx_q + W'(1);
          end else if (cy_q != ymax_q) begin
            cx_d = xmin_q;
            cy_d = cy_q + W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!po_q || po_ready) begin
          po_d   = 1'b0;
          done_d = 1'b1;
        end
      end
      S_DONE: begin
        po_d   = 1'b0;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= 2'd0;
      x0_q   <= '0; y0_q <= '0;
      x1_q   <= '0; y1_q <= '0;
      x2_q   <= '0; y2_q <= '0;
      eo_q   <= 1'b0;
      xmin_q <= '0; xmax_q <= '0;
      ymin_q <= '0; ymax_q <= '0;
      cx_q   <= '0; cy_q <= '0;
      po_q   <= 1'b0;
      xo_q   <= '0; yo_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      x0_q   <= x0_d; y0_q <= y0_d;
      x1_q   <= x1_d; y1_q <= y1_d;
      x2_q   <= x2_d; y2_q <= y2_d;
      eo_q   <= eo_d;
      xmin_q <= xmin_d; xmax_q <= xmax_d;
      ymin_q <= ymin_d; ymax_q <= ymax_d;
      cx_q   <= cx_d; cy_q <= cy_d;
      po_q   <= po_d;
      xo_q   <= xo_d; yo_q <= yo_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign po   = po_q;
  assign xo   = xo_q;
  assign yo   = yo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_triangle_raster_gen.sv
// Directed bench for triangle_raster_gen: hand-derived point lists, latency,
// backpressure freezing, mid-scan reset and vertex filtering while busy.
module tb_triangle_raster_gen;

  localparam int unsigned W = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         vin_valid;
  logic         vin_ready;
  logic [W-1:0] xi, yi;
  logic         edge_only;
  logic         busy, po, po_ready, done;
  logic [W-1:0] xo, yo;

  int total = 0;
  int bad   = 0;
  int got_q[$];
  int exp_q[$];
  int done_at, first_at;

  triangle_raster_gen #(.W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .vin_valid(vin_valid),
    .vin_ready(vin_ready),
    .xi       (xi),
    .yi       (yi),
    .edge_only(edge_only),
    .busy     (busy),
    .po       (po),
    .po_ready (po_ready),
    .xo       (xo),
    .yo       (yo),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Offers three vertices on consecutive cycles, starting and ending at a negedge.
  task automatic send(input int ax, input int ay, input int bx, input int by,
                      input int cx, input int cy, input bit eo);
    int vx[3];
    int vy[3];
    vx = '{ax, bx, cx};
    vy = '{ay, by, cy};
    for (int k = 0; k < 3; k++) begin
      chk("vin_ready_idle_send", 32'(vin_ready), 32'd1);
      vin_valid = 1'b1;
      xi        = W'(vx[k]);
      yi        = W'(vy[k]);
      edge_only = eo;
      @(negedge clk);
    end
    vin_valid = 1'b0;
  endtask

  // mode 0: ready high, 1: random ready, 2: ready low on cycles 4..6
  task automatic run(input int mode, input bit junk);
    int   done_cnt;
    bit   prev_stall;
    logic [W-1:0] pxo, pyo;
    got_q.delete();
    done_cnt   = 0;
    done_at    = -1;
    first_at   = -1;
    prev_stall = 1'b0;
    pxo        = '0;
    pyo        = '0;
    for (int i = 0; i < 400; i++) begin
      case (mode)
        0:       po_ready = 1'b1;
        1:       po_ready = 1'($urandom_range(0, 1));
        default: po_ready = !(i >= 4 && i <= 6);
      endcase
      if (junk && done_at < 0) begin
        vin_valid = 1'b1;
        xi        = '0;
        yi        = '0;
      end
      if (prev_stall) begin
        chk("stall_po", 32'(po), 32'd1);
        chk("stall_xo", 32'(xo), 32'(pxo));
        chk("stall_yo", 32'(yo), 32'(pyo));
      end
      prev_stall = po && !po_ready;
      pxo        = xo;
      pyo        = yo;
      if (po && first_at < 0) first_at = i;
      if (po && po_ready) got_q.push_back(int'(xo) * 16 + int'(yo));
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_po", 32'(po), 32'd0);
        vin_valid = 1'b0;
      end
      if (done_at >= 0 && i == done_at + 1) begin
        chk("busy_fall", 32'(busy), 32'd0);
        chk("vin_ready_after", 32'(vin_ready), 32'd1);
        break;
      end
      @(negedge clk);
    end
    vin_valid = 1'b0;
    chk("finished", 32'(done_at >= 0), 32'd1);
    chk("done_once", 32'(done_cnt), 32'd1);
  endtask

  task automatic cmp_points(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_pt%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    reset     = 1'b1;
    vin_valid = 1'b0;
    xi        = '0;
    yi        = '0;
    edge_only = 1'b0;
    po_ready  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_po", 32'(po), 32'd0);
    chk("rst_xo", 32'(xo), 32'd0);
    chk("rst_yo", 32'(yo), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_vin_ready", 32'(vin_ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    // Right triangle, filled: x,y >= 1 and x+y <= 6.
    exp_q.delete();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        if (x >= 1 && y >= 1 && x + y <= 6) exp_q.push_back(x * 16 + y);
    send(1, 1, 5, 1, 1, 5, 1'b0);
    chk("setup_busy", 32'(busy), 32'd1);
    chk("setup_vin_ready", 32'(vin_ready), 32'd0);
    chk("setup_po", 32'(po), 32'd0);
    run(0, 1'b0);
    chk("first_latency", 32'(first_at), 32'd2);
    chk("scan_length", 32'(done_at), 32'd27);
    cmp_points("tri1");

    // Opposite winding with a 3-cycle stall on the first row.
    send(1, 5, 5, 1, 1, 1, 1'b0);
    run(2, 1'b0);
    cmp_points("tri1_rev_stall");

    // Edge-only: interior points (2,2),(2,3),(3,2) drop out.
    exp_q.delete();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        if (x >= 1 && y >= 1 && x + y <= 6 && (x == 1 || y == 1 || x + y == 6))
          exp_q.push_back(x * 16 + y);
    send(1, 5, 5, 1, 1, 1, 1'b1);
    run(0, 1'b0);
    cmp_points("tri1_edge");

    // Collinear vertices reduce to the diagonal segment.
    exp_q.delete();
    for (int k = 0; k < 5; k++) exp_q.push_back(k * 16 + k);
    send(0, 0, 2, 2, 4, 4, 1'b0);
    run(1, 1'b0);
    cmp_points("degenerate");

    // Coincident vertices give one point.
    exp_q.delete();
    exp_q.push_back(3 * 16 + 4);
    send(3, 4, 3, 4, 3, 4, 1'b0);
    run(0, 1'b0);
    chk("coincident_done_at", 32'(done_at), 32'd3);
    cmp_points("coincident");

    // Full-range box: x+y >= 7, with junk vertices offered while busy.
    exp_q.delete();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        if (x + y >= 7) exp_q.push_back(x * 16 + y);
    send(7, 7, 0, 7, 7, 0, 1'b0);
    run(1, 1'b1);
    cmp_points("corner_rand");
    send(7, 7, 0, 7, 7, 0, 1'b0);
    run(0, 1'b0);
    chk("corner_done_at", 32'(done_at), 32'd66);
    cmp_points("corner");

    // Reset mid-scan aborts silently.
    po_ready = 1'b1;
    send(1, 1, 5, 1, 1, 5, 1'b0);
    for (int i = 0; i < 5; i++) @(negedge clk);
    chk("pre_reset_po", 32'(po), 32'd1);
    reset = 1'b1;
    #1;
    chk("mrst_po", 32'(po), 32'd0);
    chk("mrst_xo", 32'(xo), 32'd0);
    chk("mrst_yo", 32'(yo), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_vin_ready", 32'(vin_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_po", 32'(po), 32'd0);
    end

    exp_q.delete();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        if (x >= 1 && y >= 1 && x + y <= 6) exp_q.push_back(x * 16 + y);
    send(1, 1, 5, 1, 1, 5, 1'b0);
    run(1, 1'b0);
    cmp_points("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
